sauria_axil_to_reg: RTL and testbench
=====================================

SAURIA_AXIL_TO_REG -- requirements
Module: sauria_axil_to_reg

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI4-Lite and register-interface address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width, 32 or 64 only; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: register-access timeout in cycles; 0 disables the timeout.
REQ-004 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-005 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 s_awaddr_i/s_awvalid_i/s_awready_o  in/in/out  ADDR_WIDTH/1/1  AXI4-Lite write address channel.
REQ-008 s_wdata_i/s_wstrb_i/s_wvalid_i/s_wready_o  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  AXI4-Lite write data channel.
REQ-009 s_bresp_o/s_bvalid_o/s_bready_i  out/out/in  2/1/1  AXI4-Lite write response channel.
REQ-010 s_araddr_i/s_arvalid_i/s_arready_o  in/in/out  ADDR_WIDTH/1/1  AXI4-Lite read address channel.
REQ-011 s_rdata_o/s_rresp_o/s_rvalid_o/s_rready_i  out/out/out/in  DATA_WIDTH/2/1/1  AXI4-Lite read data channel.
REQ-012 reg_addr_o/reg_write_o/reg_wdata_o/reg_wstrb_o/reg_valid_o  out  ADDR_WIDTH/1/DATA_WIDTH/STRB_WIDTH/1  register-interface request.
REQ-013 reg_rdata_i/reg_error_i/reg_ready_i  in  DATA_WIDTH/1/1  register-interface response.
REQ-014 SHALL ignore AXI prot signals; the block has no prot ports.

Function
REQ-015 Each of AW, W and AR SHALL have a one-entry holding register with a full flag; awready/wready/arready SHALL be the negation of the corresponding full flag.
REQ-016 A channel handshake (valid && ready) SHALL set its full flag and capture the payload on the same edge.
REQ-017 FSM states SHALL be IDLE, REG_WR, REG_RD, RESP_B and RESP_R.
REQ-018 In IDLE, a write SHALL be eligible when AW and W are both full, and a read SHALL be eligible when AR is full.
REQ-019 When both are eligible, arbitration SHALL be round-robin: grant the opposite type to the last grant; after reset, write wins first.
REQ-020 On grant, the FSM SHALL move to REG_WR/REG_RD, and reg_valid_o SHALL assert the next cycle with the captured addr, wdata, wstrb and write bit; request latency from the second handshake to reg_valid_o is 1 cycle.
REQ-021 In REG_WR/REG_RD, outputs SHALL hold stable until reg_ready_i; on reg_valid_o && reg_ready_i the FSM SHALL go to RESP_B/RESP_R.
REQ-022 On a read transfer, reg_rdata_i SHALL be registered into s_rdata_o.
REQ-023 The response code SHALL be 2'b10 (SLVERR) when reg_error_i=1, else 2'b00 (OKAY).
REQ-024 When the read response is OKAY, s_rdata_o SHALL carry the registered read data; when it is SLVERR, s_rdata_o SHALL be 0.
REQ-025 The consumed holding registers SHALL be cleared on the register transfer edge, so AW/W (or AR) accept a new beat while the response is pending.
REQ-026 A timeout counter SHALL count cycles in REG_WR/REG_RD; when it reaches TIMEOUT_CYCLES without reg_ready_i, the block SHALL drop reg_valid_o, respond SLVERR with rdata 0, and enter RESP_B/RESP_R.
REQ-027 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1), and the counter SHALL clear on every grant.
REQ-028 In RESP_B/RESP_R, s_bvalid_o/s_rvalid_o SHALL hold with stable payload until the ready input is high, then the FSM SHALL return to IDLE.
REQ-029 Back-to-back throughput SHALL be at most one transaction per 3 cycles; only one register access SHALL be outstanding at any time.
REQ-030 reg_valid_o SHALL never assert outside REG_WR/REG_RD.
REQ-031 Read and write transactions SHALL never interleave on the register interface.

Reset
REQ-032 While rst_i=1 at a clock edge, the FSM SHALL be IDLE, all full flags 0, and the arbitration pointer SHALL select write.
REQ-033 While rst_i=1 at a clock edge, reg_valid_o, s_bvalid_o, s_rvalid_o, s_bresp_o, s_rresp_o, s_rdata_o and the timeout counter SHALL be 0.
REQ-034 The first cycle after reset SHALL show s_awready_o=s_wready_o=s_arready_o=1.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction without emitting a response.

Verification
REQ-036 Single write: AW 0x0000_0010 at cycle 0, W 0xDEAD_BEEF with strb 0xF at cycle 2, reg_ready=1 -> reg_valid at cycle 3 with write=1, then bvalid with OKAY.
REQ-037 Read with error: AR 0x20, reg_rdata=0x1234 and reg_error=1 -> rresp=SLVERR, rdata=0.
REQ-038 Simultaneous write and read eligible after reset -> write is served first, then read; a second simultaneous pair -> read is served first.
REQ-039 Timeout: TIMEOUT_CYCLES=4, reg_ready held 0 -> reg_valid drops after 4 cycles, bresp=SLVERR, then a new transaction completes normally.
REQ-040 Backpressure: bready=0 for 10 cycles -> bvalid and bresp stable, the next AW/W are accepted but not issued, and reg_valid stays 0 until the B handshake.
REQ-041 Reset mid-REG_RD: rst_i for 1 cycle -> all valids 0 and readies 1 the next cycle, and no R beat is produced.

Source files
------------

// File: rtl/sauria_axil_to_reg_if.sv
// AXI4-Lite slave channels plus the simple register-access request/response
// bundle. The slave modport is the bridge's view; the master modport drives it.
interface sauria_axil_to_reg_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] s_awaddr_i;
  logic                  s_awvalid_i;
  logic                  s_awready_o;

  logic [DATA_WIDTH-1:0] s_wdata_i;
  logic [STRB_WIDTH-1:0] s_wstrb_i;
  logic                  s_wvalid_i;
  logic                  s_wready_o;

  logic [1:0]            s_bresp_o;
  logic                  s_bvalid_o;
  logic                  s_bready_i;

  logic [ADDR_WIDTH-1:0] s_araddr_i;
  logic                  s_arvalid_i;
  logic                  s_arready_o;

  logic [DATA_WIDTH-1:0] s_rdata_o;
  logic [1:0]            s_rresp_o;
  logic                  s_rvalid_o;
  logic                  s_rready_i;

  logic [ADDR_WIDTH-1:0] reg_addr_o;
  logic                  reg_write_o;
  logic [DATA_WIDTH-1:0] reg_wdata_o;
  logic [STRB_WIDTH-1:0] reg_wstrb_o;
  logic                  reg_valid_o;

  logic [DATA_WIDTH-1:0] reg_rdata_i;
  logic                  reg_error_i;
  logic                  reg_ready_i;

  modport slave (
    input  s_awaddr_i, s_awvalid_i,
    output s_awready_o,
    input  s_wdata_i, s_wstrb_i, s_wvalid_i,
    output s_wready_o,
    output s_bresp_o, s_bvalid_o,
    input  s_bready_i,
    input  s_araddr_i, s_arvalid_i,
    output s_arready_o,
    output s_rdata_o, s_rresp_o, s_rvalid_o,
    input  s_rready_i,
    output reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o, reg_valid_o,
    input  reg_rdata_i, reg_error_i, reg_ready_i
  );

  modport master (
    output s_awaddr_i, s_awvalid_i,
    input  s_awready_o,
    output s_wdata_i, s_wstrb_i, s_wvalid_i,
    input  s_wready_o,
    input  s_bresp_o, s_bvalid_o,
    output s_bready_i,
    output s_araddr_i, s_arvalid_i,
    input  s_arready_o,
    input  s_rdata_o, s_rresp_o, s_rvalid_o,
    output s_rready_i,
    input  reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o, reg_valid_o,
    output reg_rdata_i, reg_error_i, reg_ready_i
  );
endinterface

// File: rtl/sauria_axil_to_reg.sv
// AXI4-Lite slave to single-outstanding register-access bridge with one-entry
// channel holding registers, round-robin read/write arbitration and access timeout.
module sauria_axil_to_reg #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sauria_axil_to_reg_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REG_WR,
    S_REG_RD,
    S_RESP_B,
    S_RESP_R
  } state_t;

  state_t                r_state;

  logic                  r_aw_full;
  logic                  r_w_full;
  logic                  r_ar_full;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_WIDTH-1:0] r_w_strb;

  logic                  r_prefer_rd;
  logic [CNT_W-1:0]      r_tcnt;

  logic                  r_reg_valid;
  logic                  r_reg_write;
  logic [ADDR_WIDTH-1:0] r_reg_addr;
  logic [DATA_WIDTH-1:0] r_reg_wdata;
  logic [STRB_WIDTH-1:0] r_reg_wstrb;

  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_wr_elig;
  logic                  w_rd_elig;
  logic                  w_grant_wr;
  logic                  w_grant_rd;
  logic                  w_xfer;
  logic                  w_timeout;
  logic                  w_wr_done;
  logic                  w_rd_done;

  always_comb begin
    w_aw_hs   = bus.s_awvalid_i & ~r_aw_full;
    w_w_hs    = bus.s_wvalid_i  & ~r_w_full;
    w_ar_hs   = bus.s_arvalid_i & ~r_ar_full;
    w_wr_elig = r_aw_full & r_w_full;
    w_rd_elig = r_ar_full;
    // r_prefer_rd only flips on a contested grant, so an uncontested grant never
    // steals the next tie from the other direction.
    w_grant_wr = (r_state == S_IDLE) & w_wr_elig & (~w_rd_elig | ~r_prefer_rd);
    w_grant_rd = (r_state == S_IDLE) & w_rd_elig & (~w_wr_elig |  r_prefer_rd);
    w_xfer     = r_reg_valid & bus.reg_ready_i;
    w_timeout  = (TIMEOUT_CYCLES != 0) & r_reg_valid & ~bus.reg_ready_i &
                 (r_tcnt == TO_LAST);
    w_wr_done  = (w_xfer | w_timeout) & (r_state == S_REG_WR);
    w_rd_done  = (w_xfer | w_timeout) & (r_state == S_REG_RD);
  end

  // Channel holding registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_ar_full <= 1'b0;
      r_aw_addr <= '0;
      r_ar_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      if (w_wr_done) begin
        r_aw_full <= 1'b0;
      end else if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= bus.s_awaddr_i;
      end

      if (w_wr_done) begin
        r_w_full <= 1'b0;
      end else if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= bus.s_wdata_i;
        r_w_strb <= bus.s_wstrb_i;
      end

      if (w_rd_done) begin
        r_ar_full <= 1'b0;
      end else if (w_ar_hs) begin
        r_ar_full <= 1'b1;
        r_ar_addr <= bus.s_araddr_i;
      end
    end
  end

  // Access FSM with registered request and response outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_prefer_rd <= 1'b0;
      r_tcnt      <= '0;
      r_reg_valid <= 1'b0;
      r_reg_write <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_wstrb <= '0;
      r_bvalid    <= 1'b0;
      r_bresp     <= '0;
      r_rvalid    <= 1'b0;
      r_rresp     <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_wr) begin
            r_state     <= S_REG_WR;
            r_reg_valid <= 1'b1;
            r_reg_write <= 1'b1;
            r_reg_addr  <= r_aw_addr;
            r_reg_wdata <= r_w_data;
            r_reg_wstrb <= r_w_strb;
            r_tcnt      <= '0;
            if (w_rd_elig) r_prefer_rd <= 1'b1;
          end else if (w_grant_rd) begin
            r_state     <= S_REG_RD;
            r_reg_valid <= 1'b1;
            r_reg_write <= 1'b0;
            r_reg_addr  <= r_ar_addr;
            r_reg_wdata <= '0;
            r_reg_wstrb <= '0;
            r_tcnt      <= '0;
            if (w_wr_elig) r_prefer_rd <= 1'b0;
          end
        end

        S_REG_WR: begin
          if (w_xfer) begin
            r_reg_valid <= 1'b0;
            r_bvalid    <= 1'b1;
            r_bresp     <= bus.reg_error_i ? RESP_SLVERR : RESP_OKAY;
            r_state     <= S_RESP_B;
          end else if (w_timeout) begin
            r_reg_valid <= 1'b0;
            r_bvalid    <= 1'b1;
            r_bresp     <= RESP_SLVERR;
            r_state     <= S_RESP_B;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end

        S_REG_RD: begin
          if (w_xfer) begin
            r_reg_valid <= 1'b0;
            r_rvalid    <= 1'b1;
            r_rresp     <= bus.reg_error_i ? RESP_SLVERR : RESP_OKAY;
            r_rdata     <= bus.reg_error_i ? '0 : bus.reg_rdata_i;
            r_state     <= S_RESP_R;
          end else if (w_timeout) begin
            r_reg_valid <= 1'b0;
            r_rvalid    <= 1'b1;
            r_rresp     <= RESP_SLVERR;
            r_rdata     <= '0;
            r_state     <= S_RESP_R;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end

        S_RESP_B: begin
          if (bus.s_bready_i) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end

        S_RESP_R: begin
          if (bus.s_rready_i) begin
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_reg_valid <= 1'b0;
          r_bvalid    <= 1'b0;
          r_rvalid    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_awready_o = ~r_aw_full;
  assign bus.s_wready_o  = ~r_w_full;
  assign bus.s_arready_o = ~r_ar_full;

  assign bus.s_bvalid_o  = r_bvalid;
  assign bus.s_bresp_o   = r_bresp;
  assign bus.s_rvalid_o  = r_rvalid;
  assign bus.s_rresp_o   = r_rresp;
  assign bus.s_rdata_o   = r_rdata;

  assign bus.reg_valid_o = r_reg_valid;
  assign bus.reg_write_o = r_reg_write;
  assign bus.reg_addr_o  = r_reg_addr;
  assign bus.reg_wdata_o = r_reg_wdata;
  assign bus.reg_wstrb_o = r_reg_wstrb;

endmodule

// File: tb/tb_sauria_axil_to_reg.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a word-addressed memory model of the register space.
module tb_sauria_axil_to_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sauria_axil_to_reg_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  sauria_axil_to_reg #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Register-space responder
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t        req_log[$];
  bit [31:0]   dev_mem[64];
  bit          resp_en   = 1'b1;
  bit          err_force = 1'b0;
  bit          use_force = 1'b0;
  logic [31:0] rdata_force = '0;
  int unsigned lat_max   = 0;
  int unsigned wait_cnt  = 0;

  // Reference model of the register space at the AXI level
  bit [31:0]   ref_mem[64];

  function automatic bit is_err_addr(input logic [31:0] a);
    return a[7:4] == 4'hE;
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] old, input logic [31:0] d,
                                      input logic [3:0] s);
    bit [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  initial begin
    bus_if.reg_ready_i = 1'b0;
    bus_if.reg_rdata_i = '0;
    bus_if.reg_error_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus_if.reg_ready_i = 1'b0;
      if (!resp_en || !bus_if.reg_valid_o || rst) begin
        wait_cnt = $urandom_range(0, lat_max);
      end else if (wait_cnt != 0) begin
        wait_cnt--;
      end else begin
        req_t r;
        bit   e;
        r.wr    = bus_if.reg_write_o;
        r.addr  = bus_if.reg_addr_o;
        r.wdata = bus_if.reg_wdata_o;
        r.wstrb = bus_if.reg_wstrb_o;
        e = err_force || is_err_addr(r.addr);
        bus_if.reg_ready_i = 1'b1;
        bus_if.reg_error_i = e;
        bus_if.reg_rdata_i = use_force ? rdata_force : dev_mem[r.addr[7:2]];
        if (r.wr && !e) dev_mem[r.addr[7:2]] = merge(dev_mem[r.addr[7:2]], r.wdata, r.wstrb);
        req_log.push_back(r);
        wait_cnt = $urandom_range(0, lat_max);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int unsigned aw_dly,
                           input int unsigned w_dly, input int unsigned b_dly,
                           output logic [1:0] resp, output bit ok);
    bit aw_done = 0, w_done = 0, b_done = 0, hs_aw, hs_w;
    int unsigned n = 0;
    resp = 2'b11;
    bus_if.s_awaddr_i = addr;
    bus_if.s_wdata_i  = data;
    bus_if.s_wstrb_i  = strb;
    while (!(aw_done && w_done) && n < 100) begin
      bus_if.s_awvalid_i = !aw_done && (n >= aw_dly);
      bus_if.s_wvalid_i  = !w_done && (n >= w_dly);
      hs_aw = bus_if.s_awvalid_i && bus_if.s_awready_o;
      hs_w  = bus_if.s_wvalid_i && bus_if.s_wready_o;
      tick();
      n++;
      aw_done |= hs_aw;
      w_done  |= hs_w;
    end
    bus_if.s_awvalid_i = 1'b0;
    bus_if.s_wvalid_i  = 1'b0;
    n = 0;
    while (!b_done && n < 100) begin
      bus_if.s_bready_i = (n >= b_dly);
      if (bus_if.s_bready_i && bus_if.s_bvalid_o) begin
        resp   = bus_if.s_bresp_o;
        b_done = 1;
      end
      tick();
      n++;
    end
    bus_if.s_bready_i = 1'b0;
    ok = aw_done && w_done && b_done;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int unsigned ar_dly,
                          input int unsigned r_dly, output logic [1:0] resp,
                          output logic [31:0] data, output bit ok);
    bit ar_done = 0, r_done = 0, hs_ar;
    int unsigned n = 0;
    resp = 2'b11;
    data = 'x;
    bus_if.s_araddr_i = addr;
    while (!ar_done && n < 100) begin
      bus_if.s_arvalid_i = (n >= ar_dly);
      hs_ar = bus_if.s_arvalid_i && bus_if.s_arready_o;
      tick();
      n++;
      ar_done |= hs_ar;
    end
    bus_if.s_arvalid_i = 1'b0;
    n = 0;
    while (!r_done && n < 100) begin
      bus_if.s_rready_i = (n >= r_dly);
      if (bus_if.s_rready_i && bus_if.s_rvalid_o) begin
        resp   = bus_if.s_rresp_o;
        data   = bus_if.s_rdata_o;
        r_done = 1;
      end
      tick();
      n++;
    end
    bus_if.s_rready_i = 1'b0;
    ok = ar_done && r_done;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.s_awaddr_i = '0; bus_if.s_awvalid_i = 0;
    bus_if.s_wdata_i = '0;  bus_if.s_wstrb_i = '0; bus_if.s_wvalid_i = 0;
    bus_if.s_bready_i = 0;  bus_if.s_araddr_i = '0; bus_if.s_arvalid_i = 0;
    bus_if.s_rready_i = 0;
    rst = 1'b1;
    tick();
    tick();
    n_tests++; if (bus_if.reg_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_reg_valid got=%b exp=0", bus_if.reg_valid_o); end
    n_tests++; if (bus_if.s_bvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid got=%b exp=0", bus_if.s_bvalid_o); end
    n_tests++; if (bus_if.s_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got=%b exp=0", bus_if.s_rvalid_o); end
    n_tests++; if (bus_if.s_bresp_o !== 2'b00) begin n_fail++; $display("FAIL rst_bresp got=%b exp=00", bus_if.s_bresp_o); end
    n_tests++; if (bus_if.s_rresp_o !== 2'b00) begin n_fail++; $display("FAIL rst_rresp got=%b exp=00", bus_if.s_rresp_o); end
    n_tests++; if (bus_if.s_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", bus_if.s_rdata_o); end
    rst = 1'b0;
    n_tests++;
    if ({bus_if.s_awready_o, bus_if.s_wready_o, bus_if.s_arready_o} !== 3'b111) begin
      n_fail++;
      $display("FAIL rst_readies got=%b%b%b exp=111", bus_if.s_awready_o, bus_if.s_wready_o, bus_if.s_arready_o);
    end
    tick();
    n_tests++; if (bus_if.reg_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_reg_valid got=%b exp=0", bus_if.reg_valid_o); end
  endtask

  task automatic test_single_write();
    bit got_b = 0;
    lat_max = 0;
    bus_if.s_awaddr_i = 32'h0000_0010;
    bus_if.s_awvalid_i = 1'b1;
    tick();
    bus_if.s_awvalid_i = 1'b0;
    n_tests++; if (bus_if.s_awready_o !== 1'b0) begin n_fail++; $display("FAIL sw_aw_full got=%b exp=0", bus_if.s_awready_o); end
    tick();
    bus_if.s_wdata_i = 32'hDEAD_BEEF;
    bus_if.s_wstrb_i = 4'hF;
    bus_if.s_wvalid_i = 1'b1;
    tick();
    bus_if.s_wvalid_i = 1'b0;
    n_tests++; if (bus_if.reg_valid_o !== 1'b0) begin n_fail++; $display("FAIL sw_early_valid got=%b exp=0", bus_if.reg_valid_o); end
    tick();
    n_tests++;
    if ({bus_if.reg_valid_o, bus_if.reg_write_o, bus_if.reg_addr_o, bus_if.reg_wdata_o, bus_if.reg_wstrb_o}
        !== {1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF}) begin
      n_fail++;
      $display("FAIL sw_request got=v%b w%b a%h d%h s%h exp=v1 w1 a00000010 ddeadbeef sf",
               bus_if.reg_valid_o, bus_if.reg_write_o, bus_if.reg_addr_o, bus_if.reg_wdata_o, bus_if.reg_wstrb_o);
    end
    bus_if.s_bready_i = 1'b1;
    for (int i = 0; i < 10 && !got_b; i++) begin
      if (bus_if.s_bvalid_o) begin
        got_b = 1;
        n_tests++; if (bus_if.s_bresp_o !== 2'b00) begin n_fail++; $display("FAIL sw_bresp got=%b exp=00", bus_if.s_bresp_o); end
      end
      tick();
    end
    bus_if.s_bready_i = 1'b0;
    n_tests++; if (!got_b) begin n_fail++; $display("FAIL sw_bvalid got=timeout exp=bvalid"); end
  endtask

  task automatic test_read_error();
    logic [1:0] resp; logic [31:0] data; bit ok;
    use_force = 1; err_force = 1; rdata_force = 32'h0000_1234;
    axi_read(32'h20, 0, 0, resp, data, ok);
    use_force = 0; err_force = 0;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rderr_done got=timeout exp=rvalid"); end
    n_tests++; if (resp !== 2'b10) begin n_fail++; $display("FAIL rderr_rresp got=%b exp=10", resp); end
    n_tests++; if (data !== 32'h0) begin n_fail++; $display("FAIL rderr_rdata got=%h exp=0", data); end
    axi_read(32'h10, 1, 2, resp, data, ok);
    n_tests++;
    if (!ok || resp !== 2'b00 || data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rd_okay got=ok%0d r%b d%h exp=ok1 r00 ddeadbeef", ok, resp, data);
    end
  endtask

  task automatic test_arbitration();
    int unsigned base;
    logic [31:0] wa, ra;
    do_reset();
    lat_max = 2;
    bus_if.s_bready_i = 1'b1;
    bus_if.s_rready_i = 1'b1;
    for (int round = 0; round < 2; round++) begin
      base = req_log.size();
      wa = 32'h80 + 4 * $urandom_range(0, 7);
      ra = 32'hA0 + 4 * $urandom_range(0, 7);
      bus_if.s_awaddr_i = wa; bus_if.s_araddr_i = ra;
      bus_if.s_wdata_i = $urandom; bus_if.s_wstrb_i = 4'hF;
      bus_if.s_awvalid_i = 1; bus_if.s_wvalid_i = 1; bus_if.s_arvalid_i = 1;
      tick();
      bus_if.s_awvalid_i = 0; bus_if.s_wvalid_i = 0; bus_if.s_arvalid_i = 0;
      for (int i = 0; i < 60 && req_log.size() < base + 2; i++) tick();
      for (int i = 0; i < 4; i++) tick();
      n_tests++;
      if (req_log.size() != base + 2) begin
        n_fail++; $display("FAIL arb_count round=%0d got=%0d exp=%0d", round, req_log.size() - base, 2);
      end else begin
        // after reset the first tie goes to the write, the next tie to the read
        bit first_wr = (round == 0);
        n_tests++;
        if (req_log[base].wr !== first_wr || req_log[base+1].wr !== !first_wr) begin
          n_fail++; $display("FAIL arb_order round=%0d got=%0d%0d exp=%0d%0d", round,
                             req_log[base].wr, req_log[base+1].wr, first_wr, !first_wr);
        end
        n_tests++;
        if ((first_wr ? req_log[base].addr : req_log[base+1].addr) !== wa ||
            (first_wr ? req_log[base+1].addr : req_log[base].addr) !== ra) begin
          n_fail++; $display("FAIL arb_addr round=%0d got=%h/%h exp=w%h r%h", round,
                             req_log[base].addr, req_log[base+1].addr, wa, ra);
        end
      end
    end
    bus_if.s_bready_i = 1'b0;
    bus_if.s_rready_i = 1'b0;
  endtask

  task automatic test_timeout();
    int unsigned high = 0;
    bit seen = 0, stop = 0;
    logic [1:0] resp; bit ok;
    resp_en = 0;
    bus_if.s_awaddr_i = 32'h30; bus_if.s_wdata_i = 32'h5555_AAAA; bus_if.s_wstrb_i = 4'hF;
    bus_if.s_awvalid_i = 1; bus_if.s_wvalid_i = 1;
    tick();
    bus_if.s_awvalid_i = 0; bus_if.s_wvalid_i = 0;
    for (int i = 0; i < 20 && !stop; i++) begin
      tick();
      if (bus_if.reg_valid_o) begin high++; seen = 1; end
      else if (seen) stop = 1;
    end
    n_tests++; if (high != 4) begin n_fail++; $display("FAIL to_valid_cycles got=%0d exp=4", high); end
    n_tests++;
    if (bus_if.s_bvalid_o !== 1'b1 || bus_if.s_bresp_o !== 2'b10) begin
      n_fail++; $display("FAIL to_bresp got=v%b r%b exp=v1 r10", bus_if.s_bvalid_o, bus_if.s_bresp_o);
    end
    bus_if.s_bready_i = 1;
    tick();
    bus_if.s_bready_i = 0;
    resp_en = 1;
    axi_write(32'h34, 32'h0BAD_F00D, 4'hF, 0, 1, 0, resp, ok);
    n_tests++; if (!ok || resp !== 2'b00) begin n_fail++; $display("FAIL to_recover got=ok%0d r%b exp=ok1 r00", ok, resp); end
  endtask

  task automatic test_backpressure();
    bit got_b = 0, b_stable = 1, idle_req = 1, acc = 0;
    logic [1:0] resp0;
    lat_max = 0;
    bus_if.s_awaddr_i = 32'h04; bus_if.s_wdata_i = 32'h1111_2222; bus_if.s_wstrb_i = 4'hF;
    bus_if.s_awvalid_i = 1; bus_if.s_wvalid_i = 1;
    tick();
    bus_if.s_awvalid_i = 0; bus_if.s_wvalid_i = 0;
    for (int i = 0; i < 20 && !got_b; i++) begin
      tick();
      got_b = bus_if.s_bvalid_o;
    end
    n_tests++; if (!got_b) begin n_fail++; $display("FAIL bp_first_b got=timeout exp=bvalid"); end
    resp0 = bus_if.s_bresp_o;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        bus_if.s_awaddr_i = 32'h08; bus_if.s_wdata_i = 32'h3333_4444;
        bus_if.s_awvalid_i = 1; bus_if.s_wvalid_i = 1;
        acc = bus_if.s_awready_o && bus_if.s_wready_o;
      end
      tick();
      bus_if.s_awvalid_i = 0; bus_if.s_wvalid_i = 0;
      if (bus_if.s_bvalid_o !== 1'b1 || bus_if.s_bresp_o !== resp0) b_stable = 0;
      if (bus_if.reg_valid_o !== 1'b0) idle_req = 0;
    end
    n_tests++; if (!acc) begin n_fail++; $display("FAIL bp_accept got=0 exp=1"); end
    n_tests++; if (!b_stable) begin n_fail++; $display("FAIL bp_b_stable got=0 exp=1"); end
    n_tests++; if (!idle_req) begin n_fail++; $display("FAIL bp_no_issue got=0 exp=1"); end
    n_tests++; if (resp0 !== 2'b00) begin n_fail++; $display("FAIL bp_bresp got=%b exp=00", resp0); end
    bus_if.s_bready_i = 1;
    tick();
    bus_if.s_bready_i = 0;
    n_tests++; if (bus_if.s_bvalid_o !== 1'b0 || bus_if.reg_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_after_b got=b%b v%b exp=b0 v0", bus_if.s_bvalid_o, bus_if.reg_valid_o);
    end
    tick();
    n_tests++; if (bus_if.reg_valid_o !== 1'b1 || bus_if.reg_addr_o !== 32'h08) begin
      n_fail++; $display("FAIL bp_second_issue got=v%b a%h exp=v1 a00000008", bus_if.reg_valid_o, bus_if.reg_addr_o);
    end
    got_b = 0;
    bus_if.s_bready_i = 1;
    for (int i = 0; i < 20 && !got_b; i++) begin
      got_b = bus_if.s_bvalid_o;
      tick();
    end
    bus_if.s_bready_i = 0;
    n_tests++; if (!got_b) begin n_fail++; $display("FAIL bp_second_b got=timeout exp=bvalid"); end
  endtask

  task automatic test_reset_mid_read();
    bit seen = 0, r_beat = 0;
    resp_en = 0;
    bus_if.s_araddr_i = 32'h3C; bus_if.s_arvalid_i = 1;
    tick();
    bus_if.s_arvalid_i = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      seen = bus_if.reg_valid_o && !bus_if.reg_write_o;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL rmr_issue got=timeout exp=read request"); end
    rst = 1;
    tick();
    rst = 0;
    n_tests++;
    if ({bus_if.reg_valid_o, bus_if.s_bvalid_o, bus_if.s_rvalid_o} !== 3'b000 ||
        {bus_if.s_awready_o, bus_if.s_wready_o, bus_if.s_arready_o} !== 3'b111) begin
      n_fail++; $display("FAIL rmr_state got=val%b%b%b rdy%b%b%b exp=val000 rdy111",
                         bus_if.reg_valid_o, bus_if.s_bvalid_o, bus_if.s_rvalid_o,
                         bus_if.s_awready_o, bus_if.s_wready_o, bus_if.s_arready_o);
    end
    resp_en = 1;
    bus_if.s_rready_i = 1;
    for (int i = 0; i < 8; i++) begin
      if (bus_if.s_rvalid_o || bus_if.reg_valid_o) r_beat = 1;
      tick();
    end
    bus_if.s_rready_i = 0;
    n_tests++; if (r_beat) begin n_fail++; $display("FAIL rmr_no_beat got=1 exp=0"); end
  endtask

  task automatic test_random();
    logic [31:0] addr, data, rd; logic [3:0] strb; logic [1:0] resp, exp_resp; bit ok, e;
    lat_max = 2;
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 7) == 0) addr = 32'hE0 + 4 * $urandom_range(0, 3);
      else                           addr = 32'h40 + 4 * $urandom_range(0, 7);
      e = is_err_addr(addr);
      exp_resp = e ? 2'b10 : 2'b00;
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), resp, ok);
        if (!e) ref_mem[addr[7:2]] = merge(ref_mem[addr[7:2]], data, strb);
        n_tests++;
        if (!ok || resp !== exp_resp) begin
          n_fail++; $display("FAIL rand_wr t=%0d a=%h got=ok%0d r%b exp=ok1 r%b", t, addr, ok, resp, exp_resp);
        end
      end else begin
        axi_read(addr, $urandom_range(0, 3), $urandom_range(0, 3), resp, rd, ok);
        n_tests++;
        if (!ok || resp !== exp_resp || rd !== (e ? 32'h0 : ref_mem[addr[7:2]])) begin
          n_fail++; $display("FAIL rand_rd t=%0d a=%h got=ok%0d r%b d%h exp=ok1 r%b d%h", t, addr, ok, resp, rd,
                             exp_resp, e ? 32'h0 : ref_mem[addr[7:2]]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_error();
    test_arbitration();
    test_timeout();
    test_backpressure();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
